// File: rtl/stream_rr_arb_ft.sv
// N-input round-robin stream arbiter into a one-entry fall-through output buffer.
// Optional packet lock (hold grant until last) is enabled by defining STREAM_ARB_PKT_LOCK_EN.
module stream_rr_arb_ft #(
  parameter int N_INP = 4,
  parameter int T_w   = 32,
  parameter int IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [N_INP-1:0]   valid_i,
  output logic [N_INP-1:0]   ready_o,
  input  logic [N_INP*T_w-1:0] data_i,
`ifdef STREAM_ARB_PKT_LOCK_EN
  input  logic [N_INP-1:0]   last_i,
`endif
  output logic               valid_o,
  input  logic               ready_i,
  output logic [T_w-1:0]     data_o,
  output logic [IDX_W-1:0]   idx_o
`ifdef STREAM_ARB_PKT_LOCK_EN
  ,
  output logic               last_o
`endif
);

  logic             full;
  logic [T_w-1:0]   buf_dat;
  logic [IDX_W-1:0] buf_idx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] nxt;
  logic [IDX_W-1:0] cand_idx;
  logic [T_w-1:0]   sel_dat;
  logic             found;
  logic             acc;
  logic             kill;
  int               cand;

`ifdef STREAM_ARB_PKT_LOCK_EN
  logic             lock;
  logic [IDX_W-1:0] lock_idx;
  logic             buf_last;
`endif

  assign kill = rst_i | clr_i;

  // Scan from ptr upwards with wrap; cand stays below N_INP so the pointer never leaves range.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_INP; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_INP) cand = cand - N_INP;
      cand_idx = IDX_W'(cand);
      if (!found && valid_i[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
`ifdef STREAM_ARB_PKT_LOCK_EN
    if (lock) begin
      found = valid_i[lock_idx];
      win   = lock_idx;
    end
`endif
  end

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N_INP; k++) begin
      if (win == IDX_W'(k)) sel_dat = data_i[k*T_w +: T_w];
    end
  end

  // Ready is withheld during reset/clear so no producer believes a dropped beat was taken.
  assign acc     = found & ~full & ~kill;
  assign ready_o = acc ? (N_INP'(1) << win) : '0;
  assign nxt     = (win == IDX_W'(N_INP - 1)) ? '0 : win + 1'b1;

  assign valid_o = ~kill & (full | acc);
  assign data_o  = full ? buf_dat : sel_dat;
  assign idx_o   = full ? buf_idx : win;
`ifdef STREAM_ARB_PKT_LOCK_EN
  assign last_o  = full ? buf_last : last_i[win];
`endif

  always_ff @(posedge clk_i) begin
    if (kill) begin
      full <= 1'b0;
      ptr  <= '0;
`ifdef STREAM_ARB_PKT_LOCK_EN
      lock     <= 1'b0;
      lock_idx <= '0;
`endif
    end else begin
      if (full) begin
        if (ready_i) full <= 1'b0;
      end else if (acc && !ready_i) begin
        full    <= 1'b1;
        buf_dat <= sel_dat;
        buf_idx <= win;
`ifdef STREAM_ARB_PKT_LOCK_EN
        buf_last <= last_i[win];
`endif
      end
      if (acc) begin
`ifdef STREAM_ARB_PKT_LOCK_EN
        lock     <= ~last_i[win];
        lock_idx <= win;
        if (last_i[win]) ptr <= nxt;
`else
        ptr <= nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arb_ft.sv
// Randomized and directed bench for stream_rr_arb_ft against a queue-based reference model.
module tb_stream_rr_arb_ft;
  localparam int N = 4;
  localparam int W = 32;
`ifdef STREAM_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i, clr_i, ready_i, valid_o;
  logic [N-1:0]   valid_i, ready_o;
  logic [N*W-1:0] data_i;
  logic [W-1:0]   data_o;
  logic [1:0]     idx_o;
`ifdef STREAM_ARB_PKT_LOCK_EN
  logic [N-1:0]   last_i;
  logic           last_o;
`endif

  stream_rr_arb_ft #(.N_INP(N), .T_w(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
`ifdef STREAM_ARB_PKT_LOCK_EN
    .last_i(last_i),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o)
`ifdef STREAM_ARB_PKT_LOCK_EN
    , .last_o(last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [W-1:0] d; int i; logic l; } beat_t;

  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] dat [N];
  logic        lst [N];
  beat_t       q[$];
  int          m_ptr = 0;
  bit          m_lock = 1'b0;
  int          m_lw = 0;
  int          m_acc;
  logic        obs_valid;
  int          obs_idx;
  logic        obs_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_winner(input logic [N-1:0] v);
    if (m_lock) return v[m_lw] ? m_lw : -1;
    for (int i = 0; i < N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // One cycle: drive, compare mid-cycle against the model, then advance the model across the edge.
  task automatic step(input logic r, input logic c, input logic [N-1:0] v, input logic rdy);
    int w;
    logic ev;
    logic [N-1:0] er;
    logic [W-1:0] ed;
    int ei;
    logic el;
    rst_i = r; clr_i = c; valid_i = v; ready_i = rdy;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = dat[k];
`ifdef STREAM_ARB_PKT_LOCK_EN
    for (int k = 0; k < N; k++) last_i[k] = lst[k];
`endif
    #4;
    w = -1; ev = 1'b0; er = '0; ed = '0; ei = 0; el = 1'b0;
    if (!(r | c)) begin
      if (q.size() > 0) begin
        ev = 1'b1; ed = q[0].d; ei = q[0].i; el = q[0].l;
      end else begin
        w = m_winner(v);
        if (w >= 0) begin
          ev = 1'b1; er[w] = 1'b1; ed = dat[w]; ei = w; el = lst[w];
        end
      end
    end
    obs_valid = valid_o;
    obs_idx   = int'(idx_o);
`ifdef STREAM_ARB_PKT_LOCK_EN
    obs_last  = last_o;
`else
    obs_last  = 1'b0;
`endif
    check("valid_o", 64'(valid_o), 64'(ev));
    check("ready_o", 64'(ready_o), 64'(er));
    if (ev) begin
      check("data_o", 64'(data_o), 64'(ed));
      check("idx_o", 64'(idx_o), 64'(ei));
`ifdef STREAM_ARB_PKT_LOCK_EN
      check("last_o", 64'(last_o), 64'(el));
`endif
    end
    m_acc = -1;
    if (r | c) begin
      q.delete(); m_ptr = 0; m_lock = 1'b0;
    end else if (q.size() > 0) begin
      if (rdy) void'(q.pop_front());
    end else if (w >= 0) begin
      m_acc = w;
      if (LOCK) begin
        m_lock = !lst[w]; m_lw = w;
        if (lst[w]) m_ptr = (w + 1) % N;
      end else begin
        m_ptr = (w + 1) % N;
      end
      if (!rdy) q.push_back('{dat[w], w, lst[w]});
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [N-1:0] pend;
    rst_i = 1'b1; clr_i = 1'b0; ready_i = 1'b0; valid_i = '0; data_i = '0;
`ifdef STREAM_ARB_PKT_LOCK_EN
    last_i = '0;
`endif
    for (int k = 0; k < N; k++) begin dat[k] = 32'hA0 + k; lst[k] = 1'b1; end
    @(posedge clk_i);
    #1;

    // reset with all inputs valid, then fall-through on the first free cycle
    step(1'b1, 1'b0, 4'b1111, 1'b1);
    step(1'b1, 1'b0, 4'b1111, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);

    // fair rotation, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 4'b1111, 1'b1);
      check("rr_seq_idx", 64'(obs_idx), 64'(i % N));
    end

    // stall: beat 0x55 from input 2 held in the buffer
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    dat[2] = 32'h55;
    step(1'b0, 1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b0000, 1'b0);
      check("stall_hold", 64'(obs_idx), 64'd2);
    end
    step(1'b0, 1'b0, 4'b0100, 1'b1);
    step(1'b0, 1'b0, 4'b0100, 1'b1);

    // sparse wrap from ptr=3
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 4'b0100, 1'b1);
    step(1'b0, 1'b0, 4'b0011, 1'b1);
    check("wrap_first", 64'(obs_idx), 64'd0);
    step(1'b0, 1'b0, 4'b0010, 1'b1);
    check("wrap_second", 64'(obs_idx), 64'd1);

    // clear while full drops the buffered beat
    dat[1] = 32'h77;
    step(1'b0, 1'b0, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check("clr_drop", 64'(obs_valid), 64'd0);

`ifdef STREAM_ARB_PKT_LOCK_EN
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lst[1] = (i == 2); lst[2] = 1'b1; dat[1] = 32'hB0 + i;
      step(1'b0, 1'b0, 4'b0110, 1'b1);
      check("lock_idx", 64'(obs_idx), 64'd1);
      check("lock_last", 64'(obs_last), 64'(i == 2));
    end
    step(1'b0, 1'b0, 4'b0100, 1'b1);
    check("lock_release", 64'(obs_idx), 64'd2);
`endif

    // randomized traffic obeying the hold-until-accepted rule
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom % 3 == 0)) begin
          pend[k] = 1'b1; dat[k] = $urandom; lst[k] = 1'($urandom % 2);
        end
      end
      r = ($urandom % 250 == 0);
      step(r, 1'($urandom % 300 == 0), pend, 1'($urandom % 4 != 0));
      if (m_acc >= 0) pend[m_acc] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_rr_arb_ft.md
Name: stream_rr_arb_ft

Overview:
- N-input round-robin stream arbiter feeding one shared one-entry fall-through output stage.
- Used wherever several producers share one downstream stream consumer, e.g. in front of a shared pipeline or memory port.
- Does not cut combinational paths: a winning input reaches the output in the same cycle when the buffer is empty.
- When the consumer stalls, the one-entry buffer absorbs one beat so the winning input still sees ready.

Parameters:
N_INP, 4, number of requesters (>=2).
T_w, 32, payload width in bits.
IDX_W, max(1,$clog2(N_INP)), width of source index (derived, not to be overridden).

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_i  in  1  synchronous active-high reset.
clr_i  in  1  synchronous clear, same effect as rst_i.
valid_i  in  N_INP  per-input valid.
ready_o  out  N_INP  per-input ready.
data_i  in  N_INP*T_w  packed payloads; input k occupies bits [k*T_w +: T_w].
valid_o  out  1  output valid.
ready_i  in  1  downstream ready.
data_o  out  T_w  output payload.
idx_o  out  IDX_W  index of the input that data_o came from.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high; it acts only on a rising clk_i edge.
- State: buffer-full flag, buffer data, buffer index, round-robin pointer ptr (IDX_W bits).
- Reset/clr (rst_i or clr_i high at a clock edge): buffer empty, ptr=0.
- Reset/clr outputs: valid_o=0; data_o and idx_o don't-care. ready_o follows the rules below on the next cycle.
- Any beat held in the buffer is discarded on reset/clr.
- Arbitration (combinational): winner w = first k with valid_i[k]=1, scanning k = ptr, ptr+1, ..., N_INP-1, 0, ..., ptr-1 (modulo N_INP).
- No winner exists when valid_i is all zero.
- ready_o:
  - ready_o[w] = ~full.
  - All other ready_o bits = 0.
  - ready_o is all zero when full or when no winner exists.
  - ready_o never depends on ready_i.
- Accept: a handshake occurs on input w when valid_i[w] & ready_o[w].
- Buffer empty, accept occurring: valid_o=1, data_o=data_i[w], idx_o=w (fall-through, zero latency).
  - If ready_i=1: the beat is consumed; the buffer stays empty.
  - If ready_i=0: the beat is captured into the buffer; full=1 next cycle.
- Buffer empty, no valid input: valid_o=0.
- Buffer full: valid_o=1, data_o and idx_o come from the buffer.
  - ready_i=1: full=0 next cycle.
  - No new input is accepted in the same cycle, even though the buffer drains (matches the standard depth-1 fall-through: no simultaneous push while full).
- Pointer update: on every accept, ptr <= (w+1) mod N_INP, wrapping N_INP-1 -> 0. No accept: ptr holds.
- Fairness: with all inputs continuously valid and ready_i=1, grants go 0,1,...,N_INP-1,0,... with one beat per cycle.
- Input rules (each is a bench assertion, not enforced by the block):
  - Once valid_i[k] is raised it stays high, with stable data, until accepted.
  - The arbiter may move the grant to another input while an ungranted valid_i[k] is pending.
- Output guarantee: once valid_o=1 is presented from the buffer, valid_o, data_o and idx_o stay stable until ready_i=1.
- Reset mid-transfer: a reset on the same edge as a handshake wins; the accepted beat is dropped and ptr=0.
- Non-power-of-2 N_INP: ptr must never take a value >= N_INP.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- When defined:
  - Adds input port last_i (N_INP bits) and output port last_o (1 bit).
  - last is stored with the buffered beat and presented on last_o.
  - After an accept with last_i[w]=0, a lock is set: the arbiter grants only w until a beat with last_i[w]=1 is accepted.
  - ptr advances only on the accept that carries last.
  - Lock is cleared by rst_i/clr_i.
- When undefined: no last ports; every beat is arbitrated independently as above.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with all valid_i=1 -> valid_o=0 and ready_o=0 during reset. First cycle after reset: ready_o=4'b0001, idx_o=0, valid_o=1 (buffer empty, fall-through).
2. Round-robin: valid_i=4'b1111, ready_i=1 for 8 cycles, data_i[k]=k+0xA0 -> idx_o sequence 0,1,2,3,0,1,2,3 and data_o = 0xA0..0xA3 repeating; one beat per cycle.
3. Stall/buffer: valid_i=4'b0100 with data 0x55, ready_i=0 -> cycle 0: accept, valid_o=1. Cycle 1: ready_o=0000, data_o=0x55, idx_o=2 held for 3 cycles. Then ready_i=1 -> beat consumed, ready_o[2]=1 the following cycle.
4. Sparse wrap: ptr=3 after a grant to input 2; valid_i=4'b0011 -> winner 0, then winner 1. ptr wraps 3 -> 0, so input 0 wins before input 1.
5. clr_i while full (buffer holding 0x77, ready_i=0) -> next cycle valid_o=0 and ptr=0; 0x77 never appears with valid_o=1.
6. STREAM_ARB_PKT_LOCK_EN: input 1 sends 3 beats with last=0,0,1 while input 2 is continuously valid -> idx_o=1,1,1, then 2; last_o=1 only on the third beat.
